// File: rtl/score_bcd_unit.sv
// Score accumulator with saturation and a sequential double-dabble converter
// that feeds packed BCD digits to the seven-segment display stage.
//
// state | meaning
// IDLE  | waiting for a changed score; snapshots it and starts a conversion
// SHIFT | one add-3 / shift-left step per cycle, SCORE_W steps in total
// DONE  | publishes the converted digits and pulses done
module score_bcd_unit #(
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        hit_valid,
    input  logic [3:0]  hit_points,
    output logic [15:0] digits,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SCORE_W - 1);
    localparam logic [SCORE_W:0]   MAX_EXT  = (SCORE_W + 1)'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] MAX_VAL  = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] score_next;
    logic [SCORE_W:0]   sum;
    logic               score_changed;
    logic               dirty;
    logic [SCORE_W-1:0] snap;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [CNT_W-1:0]   cnt;

    // Sum is one bit wider than the score so overflow past the ceiling is visible.
    always_comb begin
        sum        = {1'b0, score} + {{(SCORE_W - 3){1'b0}}, hit_points};
        score_next = score;
        if (clear) begin
            score_next = '0;
        end else if (hit_valid) begin
            score_next = (sum > MAX_EXT) ? MAX_VAL : sum[SCORE_W-1:0];
        end
        score_changed = (score_next != score);
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            score  <= '0;
            dirty  <= 1'b0;
            snap   <= '0;
            bcd    <= '0;
            cnt    <= '0;
            digits <= 16'h0000;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            score <= score_next;
            done  <= 1'b0;
            // A fresh change always re-arms dirty, even as IDLE consumes the old one.
            dirty <= score_changed | (dirty & (state != IDLE));

            case (state)
                IDLE: begin
                    if (dirty) begin
                        snap  <= score;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, snap} <= {bcd_adj, snap} << 1;
                    cnt         <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    digits <= bcd;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_unit.sv
// Directed bench for score_bcd_unit: reset, latency, accumulation, saturation,
// mid-conversion updates, clear/hit collision and reset during conversion.
module tb_score_bcd_unit;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        hit_valid;
    logic [3:0]  hit_points;
    logic [15:0] digits;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int done_total = 0;
    logic [15:0] done_log [0:1023];

    score_bcd_unit dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .hit_valid  (hit_valid),
        .hit_points (hit_points),
        .digits     (digits),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (done_total < 1024) done_log[done_total] = digits;
            done_total = done_total + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [3:0] p);
        hit_valid  = 1'b1;
        hit_points = p;
        tick(1);
        hit_valid  = 1'b0;
        hit_points = 4'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // Waits until busy has been low for 3 consecutive cycles.
    task automatic wait_quiet(input int max_cyc, input string tag);
        int idle_run = 0;
        int n = 0;
        while (idle_run < 3 && n < max_cyc) begin
            tick(1);
            n = n + 1;
            idle_run = (busy === 1'b0) ? idle_run + 1 : 0;
        end
        check_val({tag, "_settle"}, 32'(idle_run >= 3), 32'd1);
    endtask

    initial begin
        int base;
        rst        = 1'b0;
        clear      = 1'b0;
        hit_valid  = 1'b0;
        hit_points = 4'd0;

        // 1: reset
        tick(2);
        check_val("rst_digits", 32'(digits), 32'h0000);
        check_val("rst_busy",   32'(busy),   32'd0);
        check_val("rst_done",   32'(done),   32'd0);
        rst  = 1'b1;
        base = done_total;
        tick(50);
        check_val("rst_no_pulse", 32'(done_total - base), 32'd0);

        // latency: hit at edge N, digits/done after edge N+16
        hit(4'd1);
        tick(15);
        check_val("lat_done_early", 32'(done), 32'd0);
        check_val("lat_busy_mid",   32'(busy), 32'd1);
        tick(1);
        check_val("lat_done",   32'(done),   32'd1);
        check_val("lat_digits", 32'(digits), 32'h0001);
        check_val("lat_busy",   32'(busy),   32'd0);
        tick(1);
        check_val("lat_done_once", 32'(done), 32'd0);

        // 2: accumulate 5 then 7
        do_clear();
        wait_quiet(40, "t2_clr");
        base = done_total;
        hit(4'd5);
        hit(4'd7);
        wait_quiet(40, "t2");
        check_val("t2_digits", 32'(digits), 32'h0012);
        check_val("t2_busy",   32'(busy),   32'd0);
        check_val("t2_pulses", 32'((done_total - base) >= 1 && (done_total - base) <= 2), 32'd1);

        // 3: saturation
        do_clear();
        for (int i = 0; i < 666; i++) hit(4'd15);
        hit(4'd5);
        wait_quiet(60, "t3_fill");
        check_val("t3_9995", 32'(digits), 32'h9995);
        base = done_total;
        hit(4'd9);
        wait_quiet(40, "t3_sat");
        check_val("t3_9999",     32'(digits), 32'h9999);
        check_val("t3_sat_once", 32'(done_total - base), 32'd1);
        base = done_total;
        hit(4'd15);
        tick(40);
        check_val("t3_no_pulse", 32'(done_total - base), 32'd0);
        check_val("t3_hold",     32'(digits), 32'h9999);
        check_val("t3_busy",     32'(busy),   32'd0);

        // 4: update mid-conversion
        do_clear();
        wait_quiet(40, "t4_clr");
        base = done_total;
        hit(4'd3);
        tick(2);
        check_val("t4_busy", 32'(busy), 32'd1);
        hit(4'd4);
        wait_quiet(60, "t4");
        check_val("t4_pulses", 32'(done_total - base), 32'd2);
        check_val("t4_first",  32'(done_log[base]),     32'h0003);
        check_val("t4_second", 32'(done_log[base + 1]), 32'h0007);
        check_val("t4_digits", 32'(digits), 32'h0007);

        // 5: clear and hit on the same edge
        do_clear();
        hit(4'd15);
        hit(4'd15);
        hit(4'd12);
        wait_quiet(60, "t5_fill");
        check_val("t5_42", 32'(digits), 32'h0042);
        base = done_total;
        clear      = 1'b1;
        hit_valid  = 1'b1;
        hit_points = 4'd9;
        tick(1);
        clear      = 1'b0;
        hit_valid  = 1'b0;
        hit_points = 4'd0;
        wait_quiet(40, "t5");
        check_val("t5_zero",  32'(digits), 32'h0000);
        check_val("t5_pulse", 32'(done_total - base), 32'd1);

        // 6: reset during the sixth shift
        do_clear();
        for (int i = 0; i < 82; i++) hit(4'd15);
        wait_quiet(60, "t6_fill");
        check_val("t6_1230", 32'(digits), 32'h1230);
        base = done_total;
        hit(4'd4);
        tick(6);
        check_val("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check_val("t6_digits", 32'(digits), 32'h0000);
        check_val("t6_busy",   32'(busy),   32'd0);
        check_val("t6_done",   32'(done),   32'd0);
        tick(30);
        check_val("t6_no_pulse", 32'(done_total - base), 32'd0);
        check_val("t6_hold",     32'(digits), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
